// File: rtl/fp_pkg.sv
// fp_pkg: shared FSM state type, operand width helper and FP32 constants for the FP adder datapath
package fp_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} fp_arb_state_t;
  function automatic int fp_width(input int exp_bits, input int mant_bits);
    return exp_bits + mant_bits + 1;
  endfunction
  localparam logic [31:0] FP32_ONE     = 32'h3F800000;
  localparam logic [31:0] FP32_TWO     = 32'h40000000;
  localparam logic [31:0] FP32_THREE   = 32'h40400000;
  localparam logic [31:0] FP32_POS_INF = 32'h7F800000;
  localparam logic [31:0] FP32_NEG_INF = 32'hFF800000;
  localparam logic [31:0] FP32_QNAN    = 32'h7FC00000;
endpackage

// File: rtl/fp_add_arbiter_if.sv
// fp_add_arbiter_if: requester-side and adder-side signals of the shared FP adder arbiter
interface fp_add_arbiter_if
  import fp_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = fp_width(8, 23)
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0][W-1:0] req_a;
  logic [N_REQ-1:0][W-1:0] req_b;
  logic [N_REQ-1:0]        resp_valid;
  logic [W-1:0]            resp_data;
  logic                    resp_err;
  logic                    add_valid;
  logic [W-1:0]            add_a;
  logic [W-1:0]            add_b;
  logic [W-1:0]            add_data;
  logic                    add_done;
  modport slave (
    input  req_valid, req_a, req_b, add_data, add_done,
    output req_ready, resp_valid, resp_data, resp_err, add_valid, add_a, add_b
  );
  modport master (
    output req_valid, req_a, req_b, add_data, add_done,
    input  req_ready, resp_valid, resp_data, resp_err, add_valid, add_a, add_b
  );
endinterface

// File: rtl/fp_add_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick of the first request at or after ptr, wrapping
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic             any
);
  logic [N_REQ-1:0] hi;
  // lowest set bit at or above ptr, else lowest set bit overall (wrap)
  always_comb begin
    hi  = req & ~((N_REQ'(1) << ptr) - N_REQ'(1));
    gnt = |hi ? hi & (~hi + N_REQ'(1)) : req & (~req + N_REQ'(1));
    any = |req;
  end
endmodule

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin sharing of one multi-cycle FP adder; FP_ADD_ARB_TIMEOUT_EN adds a WAIT watchdog
module fp_add_arbiter
  import fp_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int EXP_BITS  = 8,
  parameter int MANT_BITS = 23,
  parameter int TIMEOUT   = 64
) (
  input logic             clk,
  input logic             reset_n,
  fp_add_arbiter_if.slave bus
);
  localparam int W  = fp_width(EXP_BITS, MANT_BITS);
  localparam int PW = $clog2(N_REQ);

  fp_arb_state_t    state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d, g_q, g_d, gidx;
  logic [W-1:0]     a_q, a_d, b_q, b_d, data_q, data_d;
  logic             err_q, err_d, any, accept, to_hit;
  logic [N_REQ-1:0] gnt;

  rr_picker #(.N_REQ(N_REQ), .PW(PW)) u_pick (
    .req (bus.req_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .any (any)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < N_REQ; i++) gidx = gnt[i] ? PW'(i) : gidx;
  end

`ifdef FP_ADD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1) > 8 ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0] cnt_q, cnt_d;
  // counter is zero on the first WAIT cycle, so RESP follows exactly TIMEOUT WAIT cycles
  always_comb begin
    cnt_d  = state_q == WAIT ? cnt_q + 1'b1 : '0;
    to_hit = state_q == WAIT && cnt_q + 1'b1 == CW'(TIMEOUT);
  end
  always_ff @(posedge clk) cnt_q <= !reset_n ? '0 : cnt_d;
`else
  // without the watchdog WAIT never gives up; the comparison is constant false
  assign to_hit = TIMEOUT < 0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = any ? ISSUE : IDLE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = bus.add_done || to_hit ? RESP : WAIT;
      default: state_d = IDLE;
    endcase
  end

  // add_done wins over a watchdog hit landing in the same cycle
  always_comb begin
    accept = state_q == IDLE && any;
    g_d    = accept ? gidx : g_q;
    a_d    = accept ? bus.req_a[gidx] : a_q;
    b_d    = accept ? bus.req_b[gidx] : b_q;
    ptr_d  = state_q == RESP ? (g_q == PW'(N_REQ - 1) ? '0 : g_q + 1'b1) : ptr_q;
    data_d = state_q != WAIT ? data_q : bus.add_done ? bus.add_data : to_hit ? '0 : data_q;
    err_d  = state_q == WAIT && !bus.add_done && to_hit;
  end

  always_comb begin
    bus.req_ready  = state_q == IDLE ? gnt : '0;
    bus.resp_valid = state_q == RESP ? N_REQ'(1) << g_q : '0;
    bus.resp_data  = data_q;
    bus.resp_err   = err_q;
    bus.add_valid  = state_q == ISSUE;
    bus.add_a      = a_q;
    bus.add_b      = b_q;
  end
endmodule

// File: doc/fp_add_arbiter.md
# fp_add_arbiter

Shares a single multi-cycle IEEE-754 `adder` instance between `N_REQ` independent requesters. The block uses round-robin arbitration. It drives the adder's `input_valid`/`in_a`/`in_b` interface, waits for `output_valid`, and returns the sum to the requester that issued it. It sits between the compute clients and the one adder in the floating-point datapath; the adder accepts one operation at a time and has no backpressure.

## Interface
- `N_REQ`, 4, number of requesters (2..16)
- `EXP_BITS`, 8, exponent width, passed through to the adder
- `MANT_BITS`, 23, mantissa width; operand width `W = EXP_BITS+MANT_BITS+1`
- `TIMEOUT`, 64, watchdog limit in cycles (used only with `FP_ADD_ARB_TIMEOUT_EN`)

- `clk`  in  1  clock
- `reset_n`  in  1  reset, synchronous, active-low
- `req_valid`  in  N_REQ  per-requester operation request
- `req_a`, `req_b`  in  N_REQ×W  per-requester operands
- `req_ready`  out  N_REQ  one-hot; operands accepted this cycle
- `resp_valid`  out  N_REQ  one-hot, one-cycle result strobe
- `resp_data`  out  W  sum, qualified by `resp_valid`
- `resp_err`  out  1  watchdog abort, qualified by `resp_valid`
- `add_valid`  out  1  to adder `input_valid`
- `add_a`, `add_b`  out  W  to adder `in_a`/`in_b`
- `add_data`  in  W  from adder `data_out`
- `add_done`  in  1  from adder `output_valid`

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any `req_valid` is high, grant `g` = first set bit at or after `ptr`, wrapping modulo `N_REQ`.
  - Assert `req_ready[g]` combinationally in that cycle.
  - Latch `req_a[g]`/`req_b[g]` and `g`, then go to ISSUE.
- **ISSUE**: `add_valid`=1 for exactly one cycle, then go to WAIT.
- **WAIT**: on `add_done`=1, latch `add_data` into `resp_data` and go to RESP.
- **RESP**
  - `resp_valid[g]`=1 for one cycle.
  - `ptr` ← (g+1) mod `N_REQ`.
  - Return to IDLE.
- `add_a`/`add_b` hold the latched operands from ISSUE until the next grant.
- `add_done` is ignored outside WAIT.
- A requester keeps `req_valid` and its operands stable until it sees `req_ready`. Dropping `req_valid` before grant withdraws the request.
- A requester may re-request in the same cycle it receives `resp_valid`. It is arbitrated in the next IDLE cycle.
- `resp_data` holds its last value between responses.

## Timing
- Reset values:
  - state IDLE, `ptr`=0
  - `req_ready`, `resp_valid`, `add_valid`, `resp_err` = 0
  - `add_a`, `add_b`, `resp_data` = 0
- Accept cycle = T.
  - `add_valid` high at T+1.
  - If the adder raises `add_done` L cycles after `input_valid`, `resp_valid` is high at T+1+L+1.
- Minimum request-to-request spacing through the block is L+3 cycles.
- Reset mid-operation discards the in-flight operation; no `resp_valid` is generated for it. The adder shares `reset_n`.
- Simultaneous requests are resolved only by `ptr`. After reset, requester 0 has top priority.

## Configuration
- `FP_ADD_ARB_TIMEOUT_EN` defined:
  - An 8-bit-or-wider counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT` without `add_done`, go to RESP with `resp_err`=1 and `resp_data`=0.
  - A late `add_done` is then ignored because the FSM is no longer in WAIT.
- Not defined: no counter; WAIT waits indefinitely and `resp_err` is tied 0.

## Structure
- Shared package `fp_pkg` holds:
  - the state enum `fp_arb_state_t`
  - a width function `fp_width(EXP_BITS,MANT_BITS)`
  - the IEEE-754 single-precision constants used by benches (`FP32_ONE`=32'h3F800000)
- Sub-module `rr_picker`: combinational round-robin search from `ptr`. Ports `req[N_REQ]`, `ptr` → `gnt` (one-hot) plus `any`.

## Test plan
- **Single operation.** After reset, req 0 sends 1.0 + 2.0 (32'h3F800000, 32'h40000000). Expect `resp_valid[0]` with `resp_data`=32'h40400000 and `resp_err`=0, arriving L+2 cycles after accept.
- **Simultaneous requests.** Reqs 0–3 all assert at once with distinct operands. Grants occur in order 0,1,2,3, each `resp_valid` one-hot, with correct sums (e.g. 1.5+(-0.5)=32'h3F800000).
- **Fairness.** Req 1 re-requests on its `resp_valid` cycle while req 3 is pending. Req 3 is granted before req 1.
- **Reset in WAIT.** Assert `reset_n`=0 for one cycle while in WAIT. No `resp_valid` appears for that operation, all outputs read 0, and the next request is granted to req 0 first.
- **Timeout (macro on, `TIMEOUT`=16).** Use a stub adder that never raises `add_done`. Expect `resp_valid[g]` with `resp_err`=1 and `resp_data`=0 exactly 17 cycles after ISSUE. A later stub `add_done` produces no response.
- **Special values.** +inf (32'h7F800000) + -inf (32'hFF800000) passes through unmodified to the adder. The adder's NaN result is returned bit-exact.
